// File: rtl/pipe_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK = WIDTH/STAGES slice resolved per stage; optional signed overflow via PIPE_ADDER_OVF_EN.
// Latency: STAGES cycles from acceptance to out_valid, plus one per stall cycle; sustains one beat per cycle.
// Backpressure: global stall -- all stages hold while out_valid & ~out_ready; in_ready is low for exactly those cycles.
module pipe_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_params
        $error("pipe_adder_nbit: WIDTH must be divisible by STAGES, STAGES in 1..WIDTH");
    end

    // Per-stage registers: a/bb skew (upper chunks still to add), lower sum chunks, carry.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic             ld    [STAGES];
    logic [CHUNK:0]   part;
    logic             adv;

    assign adv      = out_ready | ~v_q[LAST];
    assign in_ready = adv;

    always_comb begin
        part     = '0;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = sub ? 1'b1 : cin;
        ld[0]    = in_valid & adv;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            ld[k]    = adv & v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c[k]};
            nxt_s[k]                   = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            nxt_c[k]                   = part[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            if (adv) begin
                v_q[0] <= in_valid;
                for (int k = 1; k < STAGES; k++) begin
                    v_q[k] <= v_q[k-1];
                end
            end
            // Data only moves with a real beat, so bubbles leave registers untouched.
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= nxt_c[k];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = c_q[LAST];

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ld[LAST]) begin
            ovf_q <= (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
                   & (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Scoreboard bench for pipe_adder_nbit (WIDTH=16, STAGES=4): directed vectors plus randomized beats and backpressure.
module tb_pipe_adder_nbit;

    localparam int W  = 16;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout, ovf;

    pipe_adder_nbit #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
        int           stl;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   first_cyc = -1;
    bit   rnd_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        exp_t  e;
        longint u;
        int    sa, sb, r;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (ts) begin
            u = longint'(ta) + 65536 - longint'(tb_);
            r = sa - sb;
        end else begin
            u = longint'(ta) + longint'(tb_) + longint'(tc);
            r = sa + sb + int'(tc);
        end
        e.s = u[W-1:0];
        e.c = u[W];
`ifdef PIPE_ADDER_OVF_EN
        e.o = (r > 32767) || (r < -32768);
`else
        e.o = 1'b0;
`endif
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    // Monitor: samples at negedge, pushes accepted beats, pops and checks delivered results.
    logic         hold_pend = 1'b0;
    logic [W-1:0] hs;
    logic         hc, ho;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            hold_pend = 1'b0;
            first_cyc = -1;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_s", {16'd0, s}, {16'd0, hs});
                chk("hold_cout_ovf", {30'd0, cout, ovf}, {30'd0, hc, ho});
            end
            chk("in_ready", {31'd0, in_ready}, {31'd0, (out_ready | ~out_valid)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (first_cyc < 0) begin
                        first_cyc = cyc;
                        chk("latency", cyc - q[0].acc - (stall_cnt - q[0].stl), ST);
                    end
                    if (out_ready) begin
                        e = q.pop_front();
                        chk("sum", {16'd0, s}, {16'd0, e.s});
                        chk("cout", {31'd0, cout}, {31'd0, e.c});
                        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                        first_cyc = -1;
                    end
                end
            end
            hold_pend = out_valid & ~out_ready;
            hs = s; hc = cout; ho = ovf;
            if (out_valid && !out_ready) stall_cnt++;
            if (in_valid && in_ready) begin
                e = model(a, b, cin, sub);
                e.acc = cyc;
                e.stl = stall_cnt;
                q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Driver: inputs change #1 after posedge; acceptance is decided by in_ready at the following negedge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        int g = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", {16'd0, s}, 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1);
        drain();

        fork
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0003, 16'h0004, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 3; i++) send(16'h0100, W'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();

        rnd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
